twiddle_rotator: RTL and testbench
==================================

TWIDDLE_ROTATOR -- requirements
Module: twiddle_rotator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed width of each real/imaginary sample component.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input sample and index present.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_re, in_im  input  DATA_W each  signed input sample.
REQ-007 SHALL have port k  input  6  twiddle index; selects W64^k = e^(-j2πk/64).
REQ-008 SHALL have port inverse  input  1  use conjugate twiddle W64^(-k).
REQ-009 SHALL have port out_valid  output  1  rotated sample present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts output.
REQ-011 SHALL have port out_re, out_im  output  DATA_W each  signed rotated sample.
REQ-012 SHALL have port busy  output  1  any pipeline stage holds a valid sample.

Function
REQ-013 SHALL use a twiddle table T[i] = round(-256·sin(2πi/64)), 10-bit signed, range -256..256.
REQ-014 SHALL form the effective index e = k when inverse=0, and e = (64-k) mod 64 when inverse=1.
REQ-015 SHALL take twiddle real part c = T[(e+48) mod 64] and imaginary part d = T[e].
REQ-016 SHALL compute re = a·c - b·d and im = a·d + b·c at full width (DATA_W+11 bits), where a=in_re and b=in_im.
REQ-017 SHALL round each result as (x + 128) >>> 8 (arithmetic shift) and saturate it to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-018 SHALL be a 3-stage pipeline:
- S1: register inputs and look up c, d.
- S2: register the four products.
- S3: sum, round, saturate, and register the outputs.
REQ-019 SHALL have a latency of exactly 3 cycles from the accepting edge to out_valid while out_ready is held high.
REQ-020 SHALL accept one sample per cycle while out_ready=1 (sustained throughput of 1 per cycle).
REQ-021 SHALL define in_ready = !out_valid | out_ready, with a global pipeline advance enable equal to in_ready.
REQ-022 SHALL freeze all stage data and valid bits while out_valid=1 and out_ready=0.
REQ-023 SHALL hold out_re, out_im and out_valid stable until the handshake completes.
REQ-024 SHALL treat a transfer as occurring only when valid and ready are both high on a rising edge.
REQ-025 SHALL advance a bubble (valid=0) through a stage without updating that stage's data.
REQ-026 SHALL return the input unchanged (rounding exact) for k=0 with inverse at either value.
REQ-027 SHALL assert busy = OR of the S1, S2 and S3 valid bits.

Reset
REQ-028 SHALL clear all stage valid bits immediately when rst_n is low, regardless of clk.
REQ-029 SHALL drive out_valid=0, busy=0, out_re=0, out_im=0 and in_ready=1 during and after reset.
REQ-030 SHALL discard any in-flight samples on reset mid-operation; no output for them may appear after reset is released.

Structure
REQ-031 SHALL place TW_N=64, TW_W=10, TW_SHIFT=8, the quarter offset 48 and a complex-sample struct typedef in a shared FFT package.
REQ-032 SHALL realise the table as one sub-module, twiddle_lut (6-bit index in, 10-bit signed out, combinational), instantiated twice for the c and d lookups.

Verification
REQ-033 SHALL cover: in=(1000,-2000), k=16, inverse=0 -> out=(-2000,-1000) exactly 3 cycles after acceptance.
REQ-034 SHALL cover: in=(1000,-2000), k=16, inverse=1 -> out=(2000,1000).
REQ-035 SHALL cover: in=(-32768,-32768), k=8, DATA_W=16 -> out_re saturates to -32768, out_im=0.
REQ-036 SHALL cover: in=(1,0), k=1 -> out=(1,0), checking round-half-up on 255 and -25.
REQ-037 SHALL cover: stream of 10 samples with out_ready low for cycles 4-6 -> no loss or duplication, order preserved, outputs stable while stalled.
REQ-038 SHALL cover: rst_n pulsed low while 3 samples are in flight -> out_valid=0 and busy=0 immediately, and no stale outputs after release.

Source files
------------

// File: rtl/twiddle_rotator_pkg.sv
// Shared FFT constants and types for the radix-64 twiddle rotator.
package twiddle_rotator_pkg;

    localparam int TW_N     = 64;
    localparam int TW_W     = 10;
    localparam int TW_SHIFT = 8;
    localparam int TW_QOFF  = 48;

    typedef logic [5:0] tw_idx_t;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } tw_cplx_t;

    // round(256*sin(2*pi*m/64)) for the first quarter wave, m = 0..16
    function automatic logic [8:0] tw_quarter(input logic [4:0] m);
        logic [8:0] r;
        unique case (m)
            5'd0:    r = 9'd0;
            5'd1:    r = 9'd25;
            5'd2:    r = 9'd50;
            5'd3:    r = 9'd74;
            5'd4:    r = 9'd98;
            5'd5:    r = 9'd121;
            5'd6:    r = 9'd142;
            5'd7:    r = 9'd162;
            5'd8:    r = 9'd181;
            5'd9:    r = 9'd198;
            5'd10:   r = 9'd213;
            5'd11:   r = 9'd226;
            5'd12:   r = 9'd237;
            5'd13:   r = 9'd245;
            5'd14:   r = 9'd251;
            5'd15:   r = 9'd255;
            5'd16:   r = 9'd256;
            default: r = 9'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/twiddle_rotator_lut.sv
// Combinational twiddle table T[i] = round(-256*sin(2*pi*i/64)).
module twiddle_lut
    import twiddle_rotator_pkg::*;
(
    input  tw_idx_t                idx_i,
    output logic signed [TW_W-1:0] tw_o
);

    logic [4:0]             m;
    logic [4:0]             fold;
    logic signed [TW_W-1:0] mag;

    // Fold onto the quarter wave; first half of the period is negative.
    always_comb begin
        m    = idx_i[4:0];
        fold = (m > 5'd16) ? 5'(6'd32 - {1'b0, m}) : m;
        mag  = $signed({1'b0, tw_quarter(fold)});
        tw_o = idx_i[5] ? mag : -mag;
    end

endmodule

// File: rtl/twiddle_rotator.sv
// Three-stage complex rotator: sample times W64^k (or its conjugate),
// rounded and saturated back to DATA_W bits.
module twiddle_rotator
    import twiddle_rotator_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic [5:0]               k,
    input  logic                     inverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     busy
);

    localparam int PW  = DATA_W + TW_W;
    localparam int SW  = DATA_W + TW_W + 1;
    localparam int RND = 1 << (TW_SHIFT - 1);

    logic    adv;
    tw_idx_t e;
    tw_idx_t c_idx;
    tw_cplx_t tw;

    logic                     v1_q, v2_q, v3_q;
    logic signed [DATA_W-1:0] a1_q, b1_q;
    tw_cplx_t                 tw1_q;
    logic signed [PW-1:0]     ac_q, bd_q, ad_q, bc_q;
    logic signed [PW-1:0]     ac_d, bd_d, ad_d, bc_d;
    logic signed [SW-1:0]     re_sum, im_sum;
    logic signed [SW-1:0]     re_rnd, im_rnd;
    logic signed [DATA_W-1:0] re_q, im_q, re_d, im_d;

    function automatic logic signed [DATA_W-1:0] sat(
        input logic signed [SW-1:0] x
    );
        if (x[SW-1:DATA_W-1] == {(SW-DATA_W+1){x[SW-1]}})
            return x[DATA_W-1:0];
        else if (x[SW-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign e     = inverse ? 6'(7'd64 - {1'b0, k}) : k;
    assign c_idx = 6'(e + 6'(TW_QOFF));

    twiddle_lut u_lut_c (.idx_i(c_idx), .tw_o(tw.re));
    twiddle_lut u_lut_d (.idx_i(e),     .tw_o(tw.im));

    always_comb begin
        ac_d   = PW'(a1_q) * PW'($signed(tw1_q.re));
        bd_d   = PW'(b1_q) * PW'($signed(tw1_q.im));
        ad_d   = PW'(a1_q) * PW'($signed(tw1_q.im));
        bc_d   = PW'(b1_q) * PW'($signed(tw1_q.re));
        re_sum = SW'(ac_q) - SW'(bd_q);
        im_sum = SW'(ad_q) + SW'(bc_q);
        re_rnd = (re_sum + SW'(RND)) >>> TW_SHIFT;
        im_rnd = (im_sum + SW'(RND)) >>> TW_SHIFT;
        re_d   = sat(re_rnd);
        im_d   = sat(im_rnd);
    end

    assign in_ready  = !v3_q | out_ready;
    assign adv       = in_ready;
    assign out_valid = v3_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign busy      = v1_q | v2_q | v3_q;

    // Bubbles advance valid bits only; stage data holds until a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            tw1_q <= '0;
            ac_q  <= '0;
            bd_q  <= '0;
            ad_q  <= '0;
            bc_q  <= '0;
            re_q  <= '0;
            im_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                a1_q  <= in_re;
                b1_q  <= in_im;
                tw1_q <= tw;
            end
            if (v1_q) begin
                ac_q <= ac_d;
                bd_q <= bd_d;
                ad_q <= ad_d;
                bc_q <= bc_d;
            end
            if (v2_q) begin
                re_q <= re_d;
                im_q <= im_d;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rotator.sv
// Directed-vector bench for twiddle_rotator.
module tb_twiddle_rotator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re, in_im;
    logic [5:0]         k;
    logic               inverse;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re, out_im;
    logic               busy;

    int nvec  = 0;
    int nmiss = 0;

    twiddle_rotator #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .k         (k),
        .inverse   (inverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic [5:0] kk, input logic inv,
                         output logic signed [15:0] ore, output logic signed [15:0] oim,
                         output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_re     = a;
        in_im     = b;
        k         = kk;
        inverse   = inv;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        ore = out_re;
        oim = out_im;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        k         = '0;
        inverse   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0) begin
            nmiss++; $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nmiss++; $display("FAIL reset busy: got %b want 0", busy);
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nmiss++; $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
        nvec++;
        if (out_re !== 16'sd0 || out_im !== 16'sd0) begin
            nmiss++; $display("FAIL reset out: got (%0d,%0d) want (0,0)", out_re, out_im);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vector(input string name,
                               input logic signed [15:0] a, input logic signed [15:0] b,
                               input logic [5:0] kk, input logic inv,
                               input int ere, input int eim);
        logic signed [15:0] re, im;
        int lat;
        apply(a, b, kk, inv, re, im, lat);
        nvec++;
        if (lat != 3) begin
            nmiss++; $display("FAIL %s latency: got %0d want 3", name, lat);
        end
        nvec++;
        if (int'(re) != ere || int'(im) != eim) begin
            nmiss++;
            $display("FAIL %s out: got (%0d,%0d) want (%0d,%0d)", name, re, im, ere, eim);
        end
    endtask

    task automatic test_rotate();
        test_vector("rot16",     16'sd1000, -16'sd2000, 6'd16, 1'b0, -2000, -1000);
        test_vector("rot16_inv", 16'sd1000, -16'sd2000, 6'd16, 1'b1,  2000,  1000);
        test_vector("rot4",      16'sd1000,  16'sd0,    6'd4,  1'b0,   926,  -383);
    endtask

    task automatic test_saturate();
        test_vector("sat_k8", -16'sd32768, -16'sd32768, 6'd8, 1'b0, -32768, 0);
    endtask

    task automatic test_round();
        test_vector("round_pos", 16'sd1,  16'sd0, 6'd1, 1'b0,  1, 0);
        test_vector("round_neg", -16'sd1, 16'sd0, 6'd1, 1'b0, -1, 0);
    endtask

    task automatic test_k0();
        test_vector("k0_fwd", 16'sd12345, -16'sd4321, 6'd0, 1'b0, 12345, -4321);
        test_vector("k0_inv", 16'sd12345, -16'sd4321, 6'd0, 1'b1, 12345, -4321);
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int oidx = 0;
        int cyc = 0;
        int ea, eb, ere, eim;
        logic stalled = 1'b0;
        logic extra = 1'b0;
        logic signed [15:0] hre = '0;
        logic signed [15:0] him = '0;
        while (oidx < 10 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (idx < 10) begin
                in_valid = 1'b1;
                in_re    = 16'(100 * (idx + 1));
                in_im    = 16'(-7 * idx);
                k        = 6'((idx % 4) * 16);
                inverse  = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                nvec++;
                if (out_valid !== 1'b1 || out_re !== hre || out_im !== him) begin
                    nmiss++;
                    $display("FAIL stall_hold: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                             out_valid, out_re, out_im, hre, him);
                end
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                ea = 100 * (oidx + 1);
                eb = -7 * oidx;
                unique case (oidx % 4)
                    0: begin ere = ea;  eim = eb;  end
                    1: begin ere = eb;  eim = -ea; end
                    2: begin ere = -ea; eim = -eb; end
                    default: begin ere = -eb; eim = ea; end
                endcase
                nvec++;
                if (int'(out_re) != ere || int'(out_im) != eim) begin
                    nmiss++;
                    $display("FAIL stream[%0d]: got (%0d,%0d) want (%0d,%0d)",
                             oidx, out_re, out_im, ere, eim);
                end
                oidx++;
            end else if (out_valid && !out_ready) begin
                stalled = 1'b1;
                hre = out_re;
                him = out_im;
                nvec++;
                if (in_ready !== 1'b0) begin
                    nmiss++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nvec++;
        if (oidx != 10 || idx != 10) begin
            nmiss++;
            $display("FAIL stream_count: got in=%0d out=%0d want 10/10", idx, oidx);
        end
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra = 1'b1;
        end
        nvec++;
        if (extra !== 1'b0) begin
            nmiss++; $display("FAIL stream_extra: got extra output want none");
        end
    endtask

    task automatic test_reset_midflight();
        logic stale = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_re    = 16'(500 + i);
            in_im    = 16'sd0;
            k        = 6'd0;
            inverse  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        nvec++;
        if (busy !== 1'b1) begin
            nmiss++; $display("FAIL midflight_busy_pre: got %b want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            nmiss++;
            $display("FAIL midflight_async: got v=%b busy=%b want 0/0", out_valid, busy);
        end
        nvec++;
        if (in_ready !== 1'b1 || out_re !== 16'sd0 || out_im !== 16'sd0) begin
            nmiss++;
            $display("FAIL midflight_clear: got rdy=%b (%0d,%0d) want 1 (0,0)",
                     in_ready, out_re, out_im);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        nvec++;
        if (stale !== 1'b0) begin
            nmiss++; $display("FAIL midflight_stale: got stale output want none");
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_saturate();
        test_round();
        test_k0();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
